// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type and default operand width. The ALU-control decoder
// imports the same operation constants.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MADD  = 3'b100;
    localparam logic [2:0] MDU_MSUB  = 3'b101;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_t;

    // 110 and 111 are not operations; requests carrying them are dropped.
    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= MDU_MSUB;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Signed ops work on magnitudes and fix the sign up at the end.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV) ||
               (op == MDU_MADD) || (op == MDU_MSUB);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//
// Handshake: Start is sampled only while Busy=0 (the unit is idle); a
// Start with a legal Op is accepted on that edge and Busy rises right
// after it. Start while Busy=1 is ignored. Done pulses for exactly one
// cycle when HiOut/LoOut carry a new result; Busy is already low in that
// cycle, so a new Start may be accepted on the following edge. HiOut and
// LoOut hold their value until the next Done.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();

    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HiIn;
    logic [WIDTH-1:0] LoIn;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    mdu_state_t       State;   // debug view of the control FSM

    modport master (
        output Start, Op, A, B, HiIn, LoIn,
        input  Busy, Done, HiOut, LoOut, State
    );

    modport slave (
        input  Start, Op, A, B, HiIn, LoIn,
        output Busy, Done, HiOut, LoOut, State
    );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding HI/LO. One shift-add or restoring
// division step per cycle over WIDTH cycles, then a single fix-up cycle
// that applies signs, accumulation and the divide-by-zero result.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic            Clk,
    input logic            Reset,
    mult_div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_t         state_q, state_d;
    logic               accept;
    logic [CW-1:0]      count_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic               b_zero_q;
    logic [2*WIDTH-1:0] acc_q;
    // Multiplicand for multiplies, divisor for divides.
    logic [WIDTH-1:0]   opnd_q;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] work_q, work_d;
    logic               neg_res_q, neg_rem_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, result;
    logic [WIDTH-1:0]   quo, rem;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, iterate WIDTH times, one fix-up cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (bus.Start && op_is_legal(bus.Op)) begin
                    accept  = 1'b1;
                    state_d = MDU_CALC;
                end
            end
            MDU_CALC: begin
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    // Operand signs and magnitudes for the request being presented.
    always_comb begin
        sign_a = op_is_signed(bus.Op) & bus.A[WIDTH-1];
        sign_b = op_is_signed(bus.Op) & bus.B[WIDTH-1];
        mag_a  = sign_a ? -bus.A : bus.A;
        mag_b  = sign_b ? -bus.B : bus.B;
    end

    // One iteration step: shift-add for multiply, restoring step for divide.
    always_comb begin
        addend    = work_q[0] ? opnd_q : '0;
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_is_div(op_q)) begin
            if (!div_diff[WIDTH]) begin
                work_d = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
            end else begin
                work_d = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            work_d = {mul_sum, work_q[WIDTH-1:1]};
        end
    end

    // Fix-up: signs, MADD/MSUB accumulation (mod 2^64), divide by zero.
    always_comb begin
        prod   = neg_res_q ? -work_q : work_q;
        quo    = neg_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
        rem    = neg_rem_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
        result = prod;
        case (op_q)
            MDU_MADD: result = acc_q + prod;
            MDU_MSUB: result = acc_q - prod;
            MDU_DIV, MDU_DIVU: begin
                result = b_zero_q ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
            end
            default: result = prod;
        endcase
    end

    // Datapath registers: latch on accept, iterate in CALC, publish in FIX.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q   <= '0;
            op_q      <= MDU_MULT;
            a_q       <= '0;
            b_zero_q  <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            work_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                count_q   <= '0;
                op_q      <= bus.Op;
                a_q       <= bus.A;
                b_zero_q  <= (bus.B == '0);
                acc_q     <= {bus.HiIn, bus.LoIn};
                neg_res_q <= sign_a ^ sign_b;
                neg_rem_q <= sign_a;
                if (op_is_div(bus.Op)) begin
                    opnd_q <= mag_b;
                    work_q <= {{WIDTH{1'b0}}, mag_a};
                end else begin
                    opnd_q <= mag_a;
                    work_q <= {{WIDTH{1'b0}}, mag_b};
                end
            end else if (state_q == MDU_CALC) begin
                work_q  <= work_d;
                count_q <= count_q + CW'(1);
            end else if (state_q == MDU_FIX) begin
                hi_q   <= result[2*WIDTH-1:WIDTH];
                lo_q   <= result[WIDTH-1:0];
                done_q <= 1'b1;
            end
        end
    end

    assign bus.Busy  = (state_q != MDU_IDLE);
    assign bus.Done  = done_q;
    assign bus.HiOut = hi_q;
    assign bus.LoOut = lo_q;
    assign bus.State = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic Clk;
    logic Reset;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MDU_MULT:  return 64'(sa * sb);
            MDU_MULTU: return {32'd0, a} * {32'd0, b};
            MDU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            MDU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            MDU_MADD:  return {hi, lo} + 64'(sa * sb);
            MDU_MSUB:  return {hi, lo} - 64'(sa * sb);
            default:   return 64'd0;
        endcase
    endfunction

    // Expected behaviour: a request taken while idle completes 33 edges later.
    logic [63:0] exp_q[$];
    logic [63:0] exp_hilo;
    bit          exp_busy;
    bit          exp_done;
    bit          pend;
    int          edge_cnt;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            exp_q.delete();
            exp_hilo = 64'd0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            pend     = 1'b0;
            edge_cnt = 0;
        end else begin
            exp_done = 1'b0;
            if (pend) begin
                edge_cnt++;
                if (edge_cnt == 33) begin
                    exp_hilo = exp_q.pop_front();
                    exp_done = 1'b1;
                    pend     = 1'b0;
                end
            end else if (bus.Start && bus.Op <= MDU_MSUB) begin
                exp_q.push_back(model(bus.Op, bus.A, bus.B, bus.HiIn, bus.LoIn));
                pend     = 1'b1;
                edge_cnt = 0;
            end
            exp_busy = pend;
        end
    end

    // Scoreboard compare on every falling edge outside reset.
    always @(negedge Clk) begin
        if (!Reset) begin
            check("busy", 64'(bus.Busy), 64'(exp_busy));
            check("done", 64'(bus.Done), 64'(exp_done));
            check("hi", 64'(bus.HiOut), 64'(exp_hilo[63:32]));
            check("lo", 64'(bus.LoOut), 64'(exp_hilo[31:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.Done && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.HiIn  = hi;
        bus.LoIn  = lo;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.HiIn  = $urandom;
        bus.LoIn  = $urandom;
        wait_done(n);
        check({name, "_latency"}, 64'(n), 64'd33);
        check({name, "_hi"}, 64'(bus.HiOut), 64'(exp_hi));
        check({name, "_lo"}, 64'(bus.LoOut), 64'(exp_lo));
        @(posedge Clk);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo, exp_hi, exp_lo;
    } vec_t;

    vec_t vecs[] = '{
        '{MDU_MULT,  32'hFFFF_FFFF, 32'h2,         32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{MDU_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h0,         32'h0,         32'h0000_0001, 32'hFFFF_FFFE},
        '{MDU_DIV,   32'hFFFF_FFF9, 32'h2,         32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD},
        '{MDU_DIVU,  32'h7,         32'h2,         32'h0,         32'h0,         32'h1,         32'h3},
        '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         32'h8000_0000},
        '{MDU_DIVU,  32'h5,         32'h0,         32'h0,         32'h0,         32'h5,         32'hFFFF_FFFF},
        '{MDU_MADD,  32'h1,         32'h1,         32'h0,         32'hFFFF_FFFF, 32'h1,         32'h0},
        '{MDU_MSUB,  32'h1,         32'h1,         32'h0,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{MDU_MULT,  32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'h0,         32'h0,         32'h0,         32'h15},
        '{MDU_DIV,   32'h7,         32'hFFFF_FFFE, 32'h0,         32'h0,         32'h1,         32'hFFFF_FFFD},
        '{MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h3},
        '{MDU_DIV,   32'hFFFF_FFFB, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF},
        '{MDU_MSUB,  32'hFFFF_FFFE, 32'h3,         32'h0,         32'hA,         32'h0,         32'h10},
        '{MDU_MULTU, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h0,         32'h4000_0000, 32'h0},
        '{MDU_MADD,  32'h0001_0000, 32'h0001_0000, 32'h1234_5678, 32'h0,         32'h1234_5679, 32'h0},
        '{MDU_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0,         32'h0,         32'hF,         32'h0FFF_FFFF}
    };

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int dones;
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Op    = MDU_MULT;
        bus.A     = '0;
        bus.B     = '0;
        bus.HiIn  = '0;
        bus.LoIn  = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.Done), 64'd0);
        check("reset_hi", 64'(bus.HiOut), 64'd0);
        check("reset_lo", 64'(bus.LoOut), 64'd0);
        check("reset_state", 64'(bus.State), 64'(MDU_IDLE));
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Leave a nonzero result in HI/LO so the abort below has to clear it.
        run_op("pre_abort", MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFE);

        // Reset in the middle of a MULT.
        bus.Start = 1'b1;
        bus.Op    = MDU_MULT;
        bus.A     = 32'd3;
        bus.B     = 32'd4;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        check("abort_busy_before", 64'(bus.Busy), 64'd1);
        Reset = 1'b1;
        #1;
        check("abort_busy", 64'(bus.Busy), 64'd0);
        check("abort_done", 64'(bus.Done), 64'd0);
        check("abort_hi", 64'(bus.HiOut), 64'd0);
        check("abort_lo", 64'(bus.LoOut), 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (bus.Done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_op("after_abort", MDU_MULTU, 32'd3, 32'd4, 32'h0, 32'h0, 32'h0, 32'h0000_000C);

        // Directed table.
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Start while busy is ignored.
        bus.Start = 1'b1;
        bus.Op    = MDU_DIVU;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        bus.Start = 1'b1;
        bus.Op    = MDU_MULTU;
        bus.A     = 32'd2;
        bus.B     = 32'd2;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        check("busy_ignore_busy", 64'(bus.Busy), 64'd1);
        wait_done(n);
        check("busy_ignore_latency", 64'(n), 64'd28);
        check("busy_ignore_hi", 64'(bus.HiOut), 64'd2);
        check("busy_ignore_lo", 64'(bus.LoOut), 64'd14);
        dones = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (bus.Done) dones++;
        end
        check("busy_ignore_no_extra", 64'(dones), 64'd0);

        // Illegal ops in IDLE.
        for (int k = 6; k < 8; k++) begin
            bus.Start = 1'b1;
            bus.Op    = 3'(k);
            bus.A     = 32'd1;
            bus.B     = 32'd1;
            @(posedge Clk);
            #1;
            bus.Start = 1'b0;
            check($sformatf("illegal_op%0d_busy", k), 64'(bus.Busy), 64'd0);
            @(posedge Clk);
            #1;
        end

        // Start held across Done: second op accepted on the edge after Done.
        bus.Start = 1'b1;
        bus.Op    = MDU_MULTU;
        bus.A     = 32'd3;
        bus.B     = 32'd5;
        @(posedge Clk);
        #1;
        bus.A = 32'd6;
        bus.B = 32'd7;
        wait_done(n);
        check("held_first_latency", 64'(n), 64'd33);
        check("held_first_hi", 64'(bus.HiOut), 64'd0);
        check("held_first_lo", 64'(bus.LoOut), 64'd15);
        check("held_busy_in_done", 64'(bus.Busy), 64'd0);
        @(posedge Clk);
        #1;
        check("held_second_accepted", 64'(bus.Busy), 64'd1);
        bus.Start = 1'b0;
        wait_done(n);
        check("held_second_latency", 64'(n), 64'd33);
        check("held_second_hi", 64'(bus.HiOut), 64'd0);
        check("held_second_lo", 64'(bus.LoOut), 64'd42);
        repeat (3) @(posedge Clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the EX stage of the MIPS pipeline, directly upstream of the HI and LO registers. It accepts MULT/MULTU/DIV/DIVU/MADD/MSUB requests with a start/busy/done handshake. It computes the 64-bit result over 32 iterations and presents {HiOut, LoOut} for the HI/LO registers to capture. The hazard unit stalls on Busy.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH
- Clk  in  1  clock, rising-edge
- Reset  in  1  asynchronous, active-high; clears all state and outputs
- Start  in  1  request; sampled only in IDLE
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB; 110/111 illegal
- A  in  WIDTH  rs operand (multiplicand / dividend)
- B  in  WIDTH  rt operand (multiplier / divisor)
- HiIn, LoIn  in  WIDTH each  current HI/LO values, used as accumulator by MADD/MSUB
- Busy  out  1  operation in progress
- Done  out  1  one-cycle pulse; HiOut/LoOut valid and new
- HiOut, LoOut  out  WIDTH each  result registers; hold last result until next Done

## Operation
- States: IDLE, CALC, FIX. Reset puts the FSM in IDLE with Busy=0, Done=0, HiOut=0, LoOut=0, and clears the iteration counter.
- IDLE: Start=1 with a legal Op latches Op, A, B, HiIn and LoIn, then moves to CALC with count=0. An illegal Op is ignored and the FSM stays in IDLE.
- MULT/MADD/MSUB: signed. Operands are converted to magnitudes and signs are recorded. Shift-add runs one bit per cycle.
- MULTU: unsigned shift-add.
- DIV: signed restoring division on magnitudes.
  - Quotient truncates toward zero and goes to LoOut.
  - Remainder takes the sign of the dividend and goes to HiOut.
- DIVU: unsigned restoring division.
- CALC: one iteration per cycle. After WIDTH iterations the FSM moves to FIX.
- FIX: applies the sign correction. For MADD, {HiIn,LoIn} + product is computed mod 2^64. For MSUB, {HiIn,LoIn} − product is computed mod 2^64. HiOut/LoOut are written, Done is pulsed, and the FSM returns to IDLE.
- Divide by zero: no exception and unchanged latency. Result is HiOut = A and LoOut = all-ones.
- DIV 0x80000000 / 0xFFFFFFFF: LoOut = 0x80000000, HiOut = 0 (wraps).
- Start while Busy=1 is ignored. Operand changes after acceptance have no effect.
- Reset during CALC/FIX aborts immediately. Busy, Done, HiOut and LoOut all go to 0, and Done never fires for the aborted operation.

## Timing
- Edge 0: Start sampled in IDLE. Busy=1 from just after edge 0.
- Edges 1..WIDTH: iterations. At edge WIDTH the FSM moves to FIX.
- Edge WIDTH+1 (33 for WIDTH=32):
  - HiOut/LoOut update.
  - Done=1 and Busy=0 for exactly one cycle.
  - The FSM returns to IDLE.
- A new Start may be sampled at edge WIDTH+2, including while Done is high. This gives back-to-back throughput of one operation per WIDTH+2 cycles.
- Latency is fixed for all ops and operand values.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package mdu_pkg holds:
  - Op encodings (MDU_MULT … MDU_MSUB)
  - FSM state enum
  - default WIDTH
- The ALU-control decoder imports the same Op constants.
- A single module is sufficient; no sub-module.

## Test plan
- Reset mid-operation: Start MULT A=3 B=4, assert Reset at cycle 10 → Busy=0, HiOut=LoOut=0, no Done. Then MULTU 3×4 → HiOut=0, LoOut=0x0000000C, with Done at edge 33.
- Multiply signedness:
  - MULT 0xFFFFFFFF × 2 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
  - MULTU 0xFFFFFFFF × 2 → Hi=0x00000001, Lo=0xFFFFFFFE.
- Division:
  - DIV −7/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - DIVU 7/2 → Lo=3, Hi=1.
  - DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Divide by zero: DIVU 5/0 → Hi=5, Lo=0xFFFFFFFF, with Done at edge 33.
- Accumulate:
  - MADD with HiIn=0, LoIn=0xFFFFFFFF, A=1, B=1 → Hi=1, Lo=0.
  - MSUB with HiIn=LoIn=0, A=1, B=1 → Hi=Lo=0xFFFFFFFF.
- Handshake:
  - Start DIVU 100/7, then pulse Start MULTU 2×2 at cycle 5 → ignored; result Lo=14, Hi=2.
  - Op=111 in IDLE → Busy stays 0.
  - Start held across the Done cycle → next operation accepted at edge 34.
